// File: rtl/alu_result_stage_pkg.sv
// Shared CPU definitions used by the ALU result stage: data width, the ALU
// opcode enum, compare-flag encodings, the FIFO word layout and a flag
// encoding helper.
package CPU_package;

  localparam int DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_XOR = 3'd2,
    ALU_NOT = 3'd3,
    ALU_CPR = 3'd4
  } enum_alu_opcode_t;

  localparam logic [2:0] FLAG_EQ = 3'b100;
  localparam logic [2:0] FLAG_GT = 3'b010;
  localparam logic [2:0] FLAG_LT = 3'b001;

  typedef struct packed {
    enum_alu_opcode_t        op;
    logic [DATA_WIDTH-1:0]   data;
  } alu_result_t;

  // A compare produces exactly one of equal / greater / less.
  function automatic logic flag_is_onehot(input logic [2:0] flag);
    logic ok;
    case (flag)
      FLAG_EQ, FLAG_GT, FLAG_LT: ok = 1'b1;
      default:                   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_result_stage_fifo.sv
// Generic synchronous FIFO. Full/empty are told apart by the occupancy
// counter alone; pointers wrap naturally because DEPTH is a power of two.
// Storage is not reset, only the pointers and the counter.
module alu_result_fifo #(
  parameter int  DEPTH  = 4,
  parameter type word_t = logic [7:0]
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  word_t                    wdata,
  output word_t                    rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_EMPTY = (PTR_W+1)'(0);

  word_t            mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Protect against overflow/underflow even if the caller misbehaves.
  assign push_ok_s = push && (count_r != CNT_FULL);
  assign pop_ok_s  = pop  && (count_r != CNT_EMPTY);

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;

  // Storage write; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: splits compare results (CPR) into a status register for
// branch logic and queues every other result toward writeback.
// Optional build macro ALU_RESULT_FLAG_CHECK_EN adds flag_err and rejects
// compare flags that are not one-hot.
module alu_result_stage
  import CPU_package::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  enum_alu_opcode_t              in_opcode,
  input  logic [DATA_WIDTH-1:0]         in_result,
  input  logic [2:0]                    in_flag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_result,
  output enum_alu_opcode_t              out_opcode,
  output logic [2:0]                    status_flag,
  output logic                          status_valid,
  output logic [$clog2(FIFO_DEPTH):0]   count
`ifdef ALU_RESULT_FLAG_CHECK_EN
  ,
  output logic                          flag_err
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_EMPTY = CNT_W'(0);

  logic             accept_s;
  logic             is_cpr_s;
  logic             cpr_accept_s;
  logic             push_s;
  logic             pop_s;
  logic             flag_ok_s;
  alu_result_t      wdata_s;
  alu_result_t      rdata_s;
  logic [CNT_W-1:0] count_s;
  logic [2:0]       status_flag_r;
  logic             status_valid_r;

  // Handshake: readiness depends only on occupancy, never on the opcode.
  assign in_ready     = (count_s != CNT_FULL);
  assign out_valid    = (count_s != CNT_EMPTY);
  assign accept_s     = in_valid && in_ready;
  assign is_cpr_s     = (in_opcode == ALU_CPR);
  assign cpr_accept_s = accept_s && is_cpr_s;
  assign push_s       = accept_s && !is_cpr_s;
  assign pop_s        = out_valid && out_ready;

  assign wdata_s.op   = in_opcode;
  assign wdata_s.data = in_result;

`ifdef ALU_RESULT_FLAG_CHECK_EN
  assign flag_ok_s = flag_is_onehot(in_flag);
`else
  assign flag_ok_s = 1'b1;
`endif

  alu_result_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .word_t (alu_result_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (wdata_s),
    .rdata (rdata_s),
    .count (count_s)
  );

  // Head outputs are forced to neutral values while the queue is empty.
  assign out_result   = out_valid ? rdata_s.data : {DATA_WIDTH{1'b0}};
  assign out_opcode   = out_valid ? rdata_s.op   : ALU_AND;
  assign count        = count_s;
  assign status_flag  = status_flag_r;
  assign status_valid = status_valid_r;

  // Status register: the most recent accepted (and acceptable) compare wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      status_flag_r  <= 3'b000;
      status_valid_r <= 1'b0;
    end else if (cpr_accept_s && flag_ok_s) begin
      status_flag_r  <= in_flag;
      status_valid_r <= 1'b1;
    end else begin
      status_flag_r  <= status_flag_r;
      status_valid_r <= status_valid_r;
    end
  end

`ifdef ALU_RESULT_FLAG_CHECK_EN
  logic flag_err_r;

  assign flag_err = flag_err_r;

  // Sticky error for a compare whose flags are not exactly one-hot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag_err_r <= 1'b0;
    end else if (cpr_accept_s && !flag_ok_s) begin
      flag_err_r <= 1'b1;
    end else begin
      flag_err_r <= flag_err_r;
    end
  end
`endif

endmodule
